// File: rtl/com_multi_sched.sv
// com_multi_sched: round-robin two-requester front end for the shared com_multi datapath,
// with zero-operand bypass and a watchdog that aborts hung jobs.
module com_multi_sched #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a_re,
  input  logic [2*WIDTH-1:0] req_a_im,
  input  logic [2*WIDTH-1:0] req_b_re,
  input  logic [2*WIDTH-1:0] req_b_im,
  input  logic [9:0]         req_mbit1,
  input  logic [9:0]         req_mbit2,
  output logic               mul_flag,
  output logic [WIDTH-1:0]   mul_a_re,
  output logic [WIDTH-1:0]   mul_a_im,
  output logic [WIDTH-1:0]   mul_b_re,
  output logic [WIDTH-1:0]   mul_b_im,
  output logic [4:0]         mul_mbit1,
  output logic [4:0]         mul_mbit2,
  input  logic               mul_over,
  input  logic [WIDTH-1:0]   mul_res_re,
  input  logic [WIDTH-1:0]   mul_res_im,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_re,
  output logic [WIDTH-1:0]   rsp_im,
  output logic               rsp_timeout
);
  typedef enum logic [1:0] {IDLE, RUN, DROP, RESP} state_t;
  state_t r_state, w_next;
  logic r_last_id, w_grant, w_accept, w_zero, w_to;
  logic [7:0] r_cnt;
  logic [WIDTH-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
  logic [4:0] w_m1, w_m2;
  assign w_grant   = &req_valid ? ~r_last_id : req_valid[1];
  assign w_a_re    = w_grant ? req_a_re[2*WIDTH-1:WIDTH] : req_a_re[WIDTH-1:0];
  assign w_a_im    = w_grant ? req_a_im[2*WIDTH-1:WIDTH] : req_a_im[WIDTH-1:0];
  assign w_b_re    = w_grant ? req_b_re[2*WIDTH-1:WIDTH] : req_b_re[WIDTH-1:0];
  assign w_b_im    = w_grant ? req_b_im[2*WIDTH-1:WIDTH] : req_b_im[WIDTH-1:0];
  assign w_m1      = w_grant ? req_mbit1[9:5] : req_mbit1[4:0];
  assign w_m2      = w_grant ? req_mbit2[9:5] : req_mbit2[4:0];
  // the datapath never raises over for a zero operand, so such jobs skip it
  assign w_zero    = ~|{w_a_re, w_a_im} | ~|{w_b_re, w_b_im};
  assign req_ready = (rst_n && r_state == IDLE && |req_valid) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_accept  = |(req_valid & req_ready);
  assign w_to      = (r_cnt + 8'd1) == 8'(TIMEOUT);
  assign mul_flag  = r_state == RUN;
  assign rsp_valid = r_state == RESP;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_zero ? RESP : RUN) : IDLE;
      RUN:     w_next = (mul_over || w_to) ? DROP : RUN;
      DROP:    w_next = RESP;
      default: w_next = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id   <= 1'b1;
      r_cnt       <= '0;
      mul_a_re    <= '0;
      mul_a_im    <= '0;
      mul_b_re    <= '0;
      mul_b_im    <= '0;
      mul_mbit1   <= '0;
      mul_mbit2   <= '0;
      rsp_id      <= 1'b0;
      rsp_re      <= '0;
      rsp_im      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_id   <= w_grant;
        rsp_id      <= w_grant;
        r_cnt       <= '0;
        mul_a_re    <= w_a_re;
        mul_a_im    <= w_a_im;
        mul_b_re    <= w_b_re;
        mul_b_im    <= w_b_im;
        mul_mbit1   <= w_m1;
        mul_mbit2   <= w_m2;
        rsp_re      <= '0;
        rsp_im      <= '0;
        rsp_timeout <= 1'b0;
      end
      if (r_state == RUN) begin
        r_cnt <= r_cnt + 8'd1;
        if (mul_over) begin
          rsp_re <= mul_res_re;
          rsp_im <= mul_res_im;
        end else if (w_to)
          rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_com_multi_sched.sv
// tb_com_multi_sched: directed and random jobs against a transaction-level model,
// with a stub datapath that pulses over after a programmable number of run cycles.
module tb_com_multi_sched;
  localparam int W = 16;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready;
  logic [2*W-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
  logic [9:0] req_mbit1, req_mbit2;
  logic mul_flag, mul_over;
  logic [W-1:0] mul_a_re, mul_a_im, mul_b_re, mul_b_im, mul_res_re, mul_res_im;
  logic [4:0] mul_mbit1, mul_mbit2;
  logic rsp_valid, rsp_ready, rsp_id, rsp_timeout;
  logic [W-1:0] rsp_re, rsp_im;
  logic [W-1:0] a_re[2], a_im[2], b_re[2], b_im[2];
  logic [4:0] m1[2], m2[2];
  logic [W-1:0] res_re, res_im;
  int lat, st_cnt, last_id, n_cmp, n_err;

  com_multi_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a_re(req_a_re), .req_a_im(req_a_im), .req_b_re(req_b_re), .req_b_im(req_b_im),
    .req_mbit1(req_mbit1), .req_mbit2(req_mbit2), .mul_flag(mul_flag),
    .mul_a_re(mul_a_re), .mul_a_im(mul_a_im), .mul_b_re(mul_b_re), .mul_b_im(mul_b_im),
    .mul_mbit1(mul_mbit1), .mul_mbit2(mul_mbit2), .mul_over(mul_over),
    .mul_res_re(mul_res_re), .mul_res_im(mul_res_im), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_re(rsp_re), .rsp_im(rsp_im),
    .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;
  assign req_a_re  = {a_re[1], a_re[0]};
  assign req_a_im  = {a_im[1], a_im[0]};
  assign req_b_re  = {b_re[1], b_re[0]};
  assign req_b_im  = {b_im[1], b_im[0]};
  assign req_mbit1 = {m1[1], m1[0]};
  assign req_mbit2 = {m2[1], m2[0]};
  // stub datapath: over in the lat-th cycle of mul_flag, never when lat is 0
  always @(posedge clk) st_cnt <= mul_flag ? st_cnt + 1 : 0;
  assign mul_over   = mul_flag && lat != 0 && st_cnt == lat - 1;
  assign mul_res_re = mul_over ? res_re : ~res_re;
  assign mul_res_im = mul_over ? res_im : ~res_im;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic job(input logic [1:0] v, input int lat_i, input int hold, input logic [W-1:0] rr, input logic [W-1:0] ri);
    int g, cyc, fc, le;
    logic pf, zero, et;
    logic [W-1:0] er, ei;
    g = (v == 2'b11) ? 1 - last_id : (v[1] ? 1 : 0);
    zero = ({a_re[g], a_im[g]} == 0) || ({b_re[g], b_im[g]} == 0);
    if (zero) begin le = 1; er = 0; ei = 0; et = 0; end
    else if (lat_i == 0 || lat_i > TO) begin le = TO + 2; er = 0; ei = 0; et = 1; end
    else begin le = lat_i + 2; er = rr; ei = ri; et = 0; end
    @(negedge clk);
    lat = lat_i; res_re = rr; res_im = ri; req_valid = v; rsp_ready = 1'b0;
    #1 chk("grant", {30'd0, req_ready}, 32'd1 << g);
    @(posedge clk);
    last_id = g;
    #1 req_valid = v & ~(2'b01 << g);
    cyc = 0; fc = 0; pf = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
      if (mul_flag) begin
        fc++;
        if (fc == 1) begin
          chk("mul_a", {mul_a_re, mul_a_im}, {a_re[g], a_im[g]});
          chk("mul_b", {mul_b_re, mul_b_im}, {b_re[g], b_im[g]});
          chk("mul_mbit", {mul_mbit1, mul_mbit2}, {m1[g], m2[g]});
        end
      end
      pf = mul_flag;
    end
    chk("latency", cyc, le);
    chk("flag_cycles", fc, zero ? 0 : (et ? TO : lat_i));
    chk("flag_low_before_rsp", {31'd0, pf}, 0);
    chk("rsp_id", {31'd0, rsp_id}, g);
    chk("rsp_data", {rsp_re, rsp_im}, {er, ei});
    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, et});
    chk("ready_busy", {30'd0, req_ready}, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", {rsp_re, rsp_im}, {er, ei});
      chk("hold_ctl", {27'd0, rsp_valid, rsp_id, rsp_timeout, req_ready}, {27'd0, 1'b1, g[0], et, 2'b00});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; last_id = 1; lat = 0;
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0; res_re = 0; res_im = 0;
    for (int r = 0; r < 2; r++) begin
      a_re[r] = 0; a_im[r] = 0; b_re[r] = 0; b_im[r] = 0; m1[r] = 0; m2[r] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_ctl", {28'd0, mul_flag, rsp_valid, req_ready}, 0);
    chk("reset_rsp", {rsp_re, rsp_im}, 0);
    chk("reset_rsp_id_to", {30'd0, rsp_id, rsp_timeout}, 0);
    chk("reset_mul_a", {mul_a_re, mul_a_im}, 0);
    chk("reset_mul_b", {mul_b_re, mul_b_im}, 0);
    chk("reset_mbit", {22'd0, mul_mbit1, mul_mbit2}, 0);
    req_valid = 2'b00; rst_n = 1'b1;
    // single request
    a_re[0] = 16'h3C00; b_re[0] = 16'h3C00; m1[0] = 5'd9; m2[0] = 5'd7;
    job(2'b01, 5, 0, 16'h1234, 16'h0042);
    // zero bypass from requester 1
    a_re[1] = 0; a_im[1] = 0; b_re[1] = 16'h4400; b_im[1] = 16'h0123;
    job(2'b10, 3, 0, 16'hAAAA, 16'h5555);
    // round-robin with both held
    a_re[0] = 16'h1111; a_im[0] = 16'h0101; a_re[1] = 16'h2222; a_im[1] = 16'h0202;
    b_re[0] = 16'h3333; b_re[1] = 16'h4444; m1[1] = 5'd3; m2[1] = 5'd12;
    for (int i = 0; i < 4; i++) job(2'b11, 2 + i, 0, 16'(i * 16'h0111), 16'(16'hF000 - i));
    // timeout then normal recovery
    job(2'b01, 0, 0, 16'h7777, 16'h8888);
    job(2'b01, 5, 0, 16'h0F0F, 16'hF0F0);
    // backpressure with the other requester pending
    job(2'b11, 4, 10, 16'hBEEF, 16'hCAFE);
    job(2'b11, 6, 1, 16'hFACE, 16'hD00D);
    // reset in the third cycle of mul_flag
    @(negedge clk);
    lat = 0; req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("flag_before_reset", {31'd0, mul_flag}, 1);
    rst_n = 1'b0;
    #1 chk("reset_mid_run", {30'd0, mul_flag, rsp_valid}, 0);
    chk("reset_mid_run_ops", {mul_a_re, mul_a_im}, 0);
    @(negedge clk);
    rst_n = 1'b1; last_id = 1;
    job(2'b11, 3, 0, 16'h1357, 16'h2468);
    // randomized jobs
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 2; r++) begin
        a_re[r] = $urandom_range(0, 5) == 0 ? 16'd0 : 16'($urandom);
        a_im[r] = a_re[r] == 0 ? 16'd0 : 16'($urandom);
        b_re[r] = $urandom_range(0, 7) == 0 ? 16'd0 : 16'($urandom);
        b_im[r] = b_re[r] == 0 ? 16'd0 : 16'($urandom);
        m1[r] = 5'($urandom); m2[r] = 5'($urandom);
      end
      job(2'($urandom_range(1, 3)), $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 12)),
          $urandom_range(0, 3), 16'($urandom), 16'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
